// File: rtl/cc_pkg.sv
// Shared types, NZP constants and the bus-value to condition-code decode
// used by the CC/BEN unit.
package cc_pkg;

    typedef logic [2:0] nzp_t;

    localparam nzp_t NZP_N     = 3'b100;
    localparam nzp_t NZP_Z     = 3'b010;
    localparam nzp_t NZP_P     = 3'b001;
    localparam nzp_t NZP_RESET = NZP_Z;

    // Widest bus the decode accepts; callers zero-extend into this width.
    localparam int unsigned CC_MAX_W = 64;

    function automatic nzp_t cc_decode(
        input logic [CC_MAX_W-1:0] data,
        input int unsigned         width,
        input logic                unsigned_md
    );
        logic [CC_MAX_W-1:0] msb_mask;
        logic                msb;
        nzp_t                cc;
        msb_mask = {{(CC_MAX_W-1){1'b0}}, 1'b1} << (width - 32'd1);
        msb      = |(data & msb_mask);
        if (data == {CC_MAX_W{1'b0}}) begin
            cc = NZP_Z;
        end else if (!unsigned_md && msb) begin
            cc = NZP_N;
        end else begin
            cc = NZP_P;
        end
        return cc;
    endfunction

endpackage

// File: rtl/cc_ben_unit_lifo.sv
// Saved-CC LIFO: stores condition codes on interrupt entry and returns them on RTI.
// Push/pop against full/empty are ignored and flagged; the caller never requests both.
module cc_lifo import cc_pkg::*; #(
    parameter int unsigned  DEPTH = 4,
    parameter int unsigned  W     = 3,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_din,
    output logic [W-1:0]  o_dout,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_err_ovf,
    output logic          o_err_unf
);

    localparam int unsigned    AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [CW-1:0] r_count;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == {CW{1'b0}});
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_err_ovf = i_push & o_full;
    assign o_err_unf = i_pop & o_empty;
    // Modulo-2^AW arithmetic keeps count-1 exact for any count in 1..DEPTH.
    assign w_wr_idx  = r_count[AW-1:0];
    assign w_rd_idx  = r_count[AW-1:0] - AW'(1);
    assign o_dout    = o_empty ? {W{1'b0}} : r_mem[w_rd_idx];
    assign o_count   = r_count;

    // Entry count; contents need no reset since empty slots are never read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {CW{1'b0}};
        end else if (w_do_push) begin
            r_count <= r_count + CW'(1);
        end else if (w_do_pop) begin
            r_count <= r_count - CW'(1);
        end
    end

    // Storage write on a performed push.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= i_din;
        end
    end

endmodule

// File: rtl/cc_ben_unit.sv
// Condition-code (NZP) register, branch-enable register and saved-CC stack control.
// Pop outranks LD_CC for nzp_out; push+pop together is a collision and does nothing.
module cc_ben_unit import cc_pkg::*; #(
    parameter int unsigned  DATA_W      = 16,
    parameter int unsigned  STACK_DEPTH = 4,
    parameter bit           BEN_FWD     = 1'b0,
    localparam int unsigned CNT_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              unsigned_md,
    input  logic              LD_CC,
    input  logic              LD_BEN,
    input  logic [2:0]        IR_nzp,
    input  logic              cc_push,
    input  logic              cc_pop,
    input  logic              err_clr,
    output logic [2:0]        nzp_out,
    output logic              BEN_out,
    output logic [CNT_W-1:0]  stack_count,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);

    logic [CC_MAX_W-1:0] w_data_ext;
    nzp_t                w_dec;
    nzp_t                w_ben_src;
    nzp_t                w_lifo_dout;
    nzp_t                r_nzp;
    logic                r_ben;
    logic                r_err;
    logic                w_push_req;
    logic                w_pop_req;
    logic                w_pop_done;
    logic                w_collide;
    logic                w_err_ovf;
    logic                w_err_unf;
    logic                w_new_err;

    // Zero-extend the bus into the decode function's fixed-width argument.
    always_comb begin
        w_data_ext               = {CC_MAX_W{1'b0}};
        w_data_ext[DATA_W-1:0]   = data_in;
    end

    assign w_dec      = cc_decode(w_data_ext, DATA_W, unsigned_md);
    assign w_collide  = cc_push & cc_pop;
    assign w_push_req = cc_push & ~cc_pop;
    assign w_pop_req  = cc_pop & ~cc_push;
    assign w_pop_done = w_pop_req & ~stack_empty;
    assign w_new_err  = w_collide | w_err_ovf | w_err_unf;

    // Forwarding applies only when LD_CC will actually land this cycle.
    always_comb begin
        if (BEN_FWD && LD_CC && !w_pop_done) begin
            w_ben_src = w_dec;
        end else begin
            w_ben_src = r_nzp;
        end
    end

    cc_lifo #(
        .DEPTH (STACK_DEPTH),
        .W     (3)
    ) u_lifo (
        .clk       (clk),
        .rst_n     (Reset_n),
        .i_push    (w_push_req),
        .i_pop     (w_pop_req),
        .i_din     (r_nzp),
        .o_dout    (w_lifo_dout),
        .o_count   (stack_count),
        .o_full    (stack_full),
        .o_empty   (stack_empty),
        .o_err_ovf (w_err_ovf),
        .o_err_unf (w_err_unf)
    );

    // Condition-code register: restore from stack beats a fresh load.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_nzp <= NZP_RESET;
        end else if (w_pop_done) begin
            r_nzp <= w_lifo_dout;
        end else if (LD_CC) begin
            r_nzp <= w_dec;
        end
    end

    // Branch-enable register.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ben <= 1'b0;
        end else if (LD_BEN) begin
            r_ben <= |(IR_nzp & w_ben_src);
        end
    end

    // Sticky stack error; a new error outranks a same-cycle clear.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_err <= 1'b0;
        end else if (w_new_err) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign nzp_out   = r_nzp;
    assign BEN_out   = r_ben;
    assign stack_err = r_err;

endmodule

// File: tb/tb_cc_ben_unit.sv
// Self-checking bench for cc_ben_unit: two instances (BEN_FWD=0 and 1) share stimulus;
// vector table, directed stack sequences, then random traffic against a queue model.
module tb_cc_ben_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        Reset_n;
    logic [15:0] data_in;
    logic        unsigned_md, ld_cc, ld_ben, cc_push, cc_pop, err_clr;
    logic [2:0]  ir_nzp;

    logic [2:0]  nzp0, nzp1, cnt0, cnt1;
    logic        ben0, ben1, full0, full1, empty0, empty1, err0, err1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [2:0] m_q [$];
    logic [2:0] m_nzp;
    logic       m_ben0, m_ben1, m_err;
    bit         check_model = 1'b0;

    typedef struct {
        logic [15:0] data;
        logic        um, ldcc, ldben;
        logic [2:0]  ir;
        logic        push, pop, clr;
        logic [2:0]  e_nzp;
        logic        e_ben0, e_ben1;
        logic [2:0]  e_cnt;
        logic        e_err;
    } vec_t;

    vec_t tbl [10];

    always #5 clk = ~clk;

    cc_ben_unit #(.DATA_W(16), .STACK_DEPTH(DEPTH), .BEN_FWD(1'b0)) u_dut0 (
        .clk(clk), .Reset_n(Reset_n), .data_in(data_in), .unsigned_md(unsigned_md),
        .LD_CC(ld_cc), .LD_BEN(ld_ben), .IR_nzp(ir_nzp), .cc_push(cc_push),
        .cc_pop(cc_pop), .err_clr(err_clr), .nzp_out(nzp0), .BEN_out(ben0),
        .stack_count(cnt0), .stack_full(full0), .stack_empty(empty0), .stack_err(err0)
    );

    cc_ben_unit #(.DATA_W(16), .STACK_DEPTH(DEPTH), .BEN_FWD(1'b1)) u_dut1 (
        .clk(clk), .Reset_n(Reset_n), .data_in(data_in), .unsigned_md(unsigned_md),
        .LD_CC(ld_cc), .LD_BEN(ld_ben), .IR_nzp(ir_nzp), .cc_push(cc_push),
        .cc_pop(cc_pop), .err_clr(err_clr), .nzp_out(nzp1), .BEN_out(ben1),
        .stack_count(cnt1), .stack_full(full1), .stack_empty(empty1), .stack_err(err1)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] ref_decode(input logic [15:0] d, input logic um);
        if (d == 16'd0)          return 3'b010;
        if (!um && d[15])        return 3'b100;
        return 3'b001;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_nzp  = 3'b010;
        m_ben0 = 1'b0;
        m_ben1 = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_step();
        logic [2:0] dec, nxt;
        logic       popping, bad;
        dec     = ref_decode(data_in, unsigned_md);
        popping = cc_pop && !cc_push && (m_q.size() > 0);
        bad     = (cc_push && cc_pop) ||
                  (cc_push && !cc_pop && m_q.size() == DEPTH) ||
                  (cc_pop && !cc_push && m_q.size() == 0);
        nxt = m_nzp;
        if (popping)    nxt = m_q.pop_back();
        else if (ld_cc) nxt = dec;
        if (cc_push && !cc_pop && m_q.size() < DEPTH) m_q.push_back(m_nzp);
        if (ld_ben) begin
            m_ben0 = |(ir_nzp & m_nzp);
            m_ben1 = |(ir_nzp & ((ld_cc && !popping) ? dec : m_nzp));
        end
        if (bad)          m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        m_nzp = nxt;
    endtask

    task automatic idle();
        data_in = 16'h0000; unsigned_md = 1'b0; ld_cc = 1'b0; ld_ben = 1'b0;
        ir_nzp = 3'b000; cc_push = 1'b0; cc_pop = 1'b0; err_clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (check_model) begin
            chk("rnd_nzp",   {13'd0, nzp0},  {13'd0, m_nzp});
            chk("rnd_nzp1",  {13'd0, nzp1},  {13'd0, m_nzp});
            chk("rnd_ben0",  {15'd0, ben0},  {15'd0, m_ben0});
            chk("rnd_ben1",  {15'd0, ben1},  {15'd0, m_ben1});
            chk("rnd_cnt",   {13'd0, cnt0},  16'(m_q.size()));
            chk("rnd_full",  {15'd0, full0}, {15'd0, (m_q.size() == DEPTH)});
            chk("rnd_empty", {15'd0, empty0},{15'd0, (m_q.size() == 0)});
            chk("rnd_err",   {15'd0, err0},  {15'd0, m_err});
        end
    endtask

    initial begin
        logic [2:0] pop_exp [4];
        pop_exp[0] = 3'b100; pop_exp[1] = 3'b001; pop_exp[2] = 3'b010; pop_exp[3] = 3'b100;

        //            data      um    ldcc  ldben ir      push  pop   clr   nzp     b0    b1    cnt   err
        tbl[0] = '{16'h8000, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[1] = '{16'h8000, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[2] = '{16'h0000, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[3] = '{16'h0001, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[4] = '{16'hFFFF, 1'b0, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1, 1'b0, 3'd0, 1'b0};
        tbl[5] = '{16'h1234, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1, 1'b1, 3'd0, 1'b0};
        tbl[6] = '{16'h0000, 1'b0, 1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1, 3'd0, 1'b0};
        tbl[7] = '{16'h7FFF, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b1, 3'd0, 1'b0};
        tbl[8] = '{16'hFFFF, 1'b1, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 3'd0, 1'b0};
        tbl[9] = '{16'h0000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 3'b001, 1'b1, 1'b1, 3'd0, 1'b0};

        // Initial reset
        idle();
        Reset_n = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        chk("rst_nzp",   {13'd0, nzp0},   16'h0002);
        chk("rst_ben",   {15'd0, ben0},   16'h0000);
        chk("rst_cnt",   {13'd0, cnt0},   16'h0000);
        chk("rst_empty", {15'd0, empty0}, 16'h0001);
        chk("rst_err",   {15'd0, err0},   16'h0000);
        Reset_n = 1'b1;

        // Vector table: decode, BEN with and without forwarding
        for (int i = 0; i < 10; i++) begin
            data_in = tbl[i].data; unsigned_md = tbl[i].um; ld_cc = tbl[i].ldcc;
            ld_ben = tbl[i].ldben; ir_nzp = tbl[i].ir; cc_push = tbl[i].push;
            cc_pop = tbl[i].pop; err_clr = tbl[i].clr;
            tick();
            chk($sformatf("tbl%0d_nzp", i),  {13'd0, nzp0}, {13'd0, tbl[i].e_nzp});
            chk($sformatf("tbl%0d_ben0", i), {15'd0, ben0}, {15'd0, tbl[i].e_ben0});
            chk($sformatf("tbl%0d_ben1", i), {15'd0, ben1}, {15'd0, tbl[i].e_ben1});
            chk($sformatf("tbl%0d_cnt", i),  {13'd0, cnt0}, {13'd0, tbl[i].e_cnt});
            chk($sformatf("tbl%0d_err", i),  {15'd0, err0}, {15'd0, tbl[i].e_err});
        end

        // Async reset mid-operation with count=2, BEN=1
        idle(); cc_push = 1'b1;
        tick(); tick();
        idle();
        chk("pre_rst_cnt", {13'd0, cnt0}, 16'h0002);
        chk("pre_rst_ben", {15'd0, ben0}, 16'h0001);
        #3;
        Reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst_nzp", {13'd0, nzp0}, 16'h0002);
        chk("arst_ben", {15'd0, ben0}, 16'h0000);
        chk("arst_cnt", {13'd0, cnt0}, 16'h0000);
        chk("arst_err", {15'd0, err0}, 16'h0000);
        @(negedge clk);
        Reset_n = 1'b1;

        // Fill to overflow while loading new CCs
        idle(); ld_cc = 1'b1; data_in = 16'h8000; tick();
        cc_push = 1'b1;
        data_in = 16'h0000; tick();
        data_in = 16'h0001; tick();
        data_in = 16'h8000; tick();
        data_in = 16'h0000; tick();
        chk("fill_cnt",  {13'd0, cnt0},  16'h0004);
        chk("fill_full", {15'd0, full0}, 16'h0001);
        chk("fill_err",  {15'd0, err0},  16'h0000);
        chk("fill_nzp",  {13'd0, nzp0},  16'h0002);
        ld_cc = 1'b0; tick();
        chk("ovf_cnt", {13'd0, cnt0}, 16'h0004);
        chk("ovf_err", {15'd0, err0}, 16'h0001);
        chk("ovf_nzp", {13'd0, nzp0}, 16'h0002);
        idle(); cc_pop = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("pop%0d_nzp", k), {13'd0, nzp0}, {13'd0, pop_exp[k]});
            chk($sformatf("pop%0d_cnt", k), {13'd0, cnt0}, 16'(3 - k));
        end
        chk("pop_empty", {15'd0, empty0}, 16'h0001);
        tick();
        chk("unf_nzp", {13'd0, nzp0}, 16'h0004);
        chk("unf_err", {15'd0, err0}, 16'h0001);
        chk("unf_cnt", {13'd0, cnt0}, 16'h0000);

        // Push/pop collision with one entry, then clear
        idle(); err_clr = 1'b1; tick();
        chk("clr_err", {15'd0, err0}, 16'h0000);
        idle(); cc_push = 1'b1; tick();
        cc_pop = 1'b1; tick();
        chk("coll_cnt", {13'd0, cnt0}, 16'h0001);
        chk("coll_nzp", {13'd0, nzp0}, 16'h0004);
        chk("coll_err", {15'd0, err0}, 16'h0001);
        idle(); err_clr = 1'b1; tick();
        chk("coll_clr", {15'd0, err0}, 16'h0000);

        // Pop beats LD_CC; BEN uses the old nzp
        idle(); ld_cc = 1'b1; data_in = 16'h0001; tick();
        idle(); cc_pop = 1'b1; ld_cc = 1'b1; data_in = 16'h0000; ld_ben = 1'b1; ir_nzp = 3'b111;
        tick();
        chk("popld_nzp",  {13'd0, nzp0}, 16'h0004);
        chk("popld_ben0", {15'd0, ben0}, 16'h0001);
        chk("popld_ben1", {15'd0, ben1}, 16'h0001);
        chk("popld_cnt",  {13'd0, cnt0}, 16'h0000);
        // Same, with a mask that would expose forwarding of the dropped load
        idle(); cc_push = 1'b1; ld_cc = 1'b1; data_in = 16'h0001; tick();
        idle(); cc_pop = 1'b1; ld_cc = 1'b1; data_in = 16'h0000; ld_ben = 1'b1; ir_nzp = 3'b010;
        tick();
        chk("popfwd_nzp",  {13'd0, nzp0}, 16'h0004);
        chk("popfwd_ben0", {15'd0, ben0}, 16'h0000);
        chk("popfwd_ben1", {15'd0, ben1}, 16'h0000);
        // Underflow and clear in the same cycle: error wins
        idle(); cc_pop = 1'b1; err_clr = 1'b1; tick();
        chk("errwin_err", {15'd0, err0}, 16'h0001);

        // Random traffic against the model
        check_model = 1'b1;
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0:       data_in = 16'h0000;
                1:       data_in = 16'h8000 | 16'($urandom);
                default: data_in = 16'($urandom);
            endcase
            unsigned_md = ($urandom_range(0, 3) == 0);
            ld_cc       = 1'($urandom);
            ld_ben      = 1'($urandom);
            ir_nzp      = 3'($urandom);
            cc_push     = ($urandom_range(0, 9) < 3);
            cc_pop      = ($urandom_range(0, 9) < 3);
            err_clr     = ($urandom_range(0, 9) == 0);
            tick();
        end
        check_model = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
